// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the TX serializer and the RX path.
// Holds the frame FSM state encoding, the parity-type constants and the
// default payload/prescale widths so both directions agree on framing.
package uart_pkg;

  // Default frame geometry
  localparam int DATA_WIDTH_DEF = 8;
  localparam int PRESCALE_W_DEF = 6;

  // PAR_TYP input encodings
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Frame FSM: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit timer for the UART transmitter.
// Counts clk cycles within a serial bit (edge_cnt 0..P-1) and data bit
// positions within the payload (bit_cnt 0..DATA_WIDTH-1).
// Ports:
//   clk, rst        clock / asynchronous active-high reset
//   active          frame in progress (FSM not IDLE); counters held at 0 otherwise
//   data_phase      FSM is in DATA; bit_cnt held at 0 otherwise
//   prescale        latched cycles-per-bit; 0 selects 2**PRESCALE_W
//   bit_tick        current cycle is the last cycle of the current serial bit
//   last_bit        bit_cnt points at the final payload bit
//   bit_nxt         value bit_cnt takes after this edge (lets the top register TX_OUT)
//   final_edge_nxt  the next cycle is the last cycle of a serial bit
import uart_pkg::*;

module uart_tx_bit_timer #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  localparam int BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  active,
  input  logic                  data_phase,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_tick,
  output logic                  last_bit,
  output logic [BIT_W-1:0]      bit_nxt,
  output logic                  final_edge_nxt
);

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] edge_nxt;
  logic [PRESCALE_W-1:0] p_last;
  logic [BIT_W-1:0]      bit_cnt;

  // prescale=0 wraps to all-ones here, giving a full 2**PRESCALE_W period.
  assign p_last   = prescale - PRESCALE_W'(1);
  assign bit_tick = active && (edge_cnt == p_last);
  assign last_bit = (bit_cnt == BIT_W'(DATA_WIDTH - 1));

  always_comb begin
    edge_nxt = '0;
    bit_nxt  = '0;
    if (active) begin
      edge_nxt = bit_tick ? '0 : edge_cnt + PRESCALE_W'(1);
    end
    if (data_phase) begin
      if (bit_tick) begin
        bit_nxt = last_bit ? '0 : bit_cnt + BIT_W'(1);
      end else begin
        bit_nxt = bit_cnt;
      end
    end
  end

  assign final_edge_nxt = (edge_nxt == p_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      edge_cnt <= edge_nxt;
      bit_cnt  <= bit_nxt;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter running on the oversampled clock shared with the RX path.
// Accepts one byte per DATA_VALID handshake while idle and sends
// start bit, data LSB first, optional parity and one stop bit, each held for
// `prescale` clk cycles (0 means 2**PRESCALE_W).
// Ports:
//   clk         oversampled clock
//   rst         asynchronous active-high reset; abandons any frame in flight
//   P_DATA      payload, sampled only in the accepting cycle
//   DATA_VALID  request; accepted when the FSM is idle
//   PAR_EN      insert a parity bit after the data
//   PAR_TYP     0 even parity, 1 odd parity
//   prescale    clk cycles per serial bit
//   TX_OUT      serial line, idles high (registered)
//   busy        frame in progress (registered)
//   frame_done  one-cycle pulse in the last stop-bit cycle (registered)
import uart_pkg::*;

module uart_tx_serializer #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  localparam int BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  frame_done
);

  tx_state_e state_q;
  tx_state_e state_nxt;

  logic [DATA_WIDTH-1:0] data_r;
  logic                  par_en_r;
  logic                  par_typ_r;
  logic [PRESCALE_W-1:0] prescale_r;

  logic                  accept;
  logic                  bit_tick;
  logic                  last_bit;
  logic [BIT_W-1:0]      bit_nxt;
  logic                  final_edge_nxt;

  logic                  tx_nxt;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                      input logic typ);
    return (typ == PAR_EVEN) ? ^d : ~^d;
  endfunction

  assign accept = (state_q == ST_IDLE) && DATA_VALID;

  uart_tx_bit_timer #(
    .DATA_WIDTH (DATA_WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) u_timer (
    .clk            (clk),
    .rst            (rst),
    .active         (state_q != ST_IDLE),
    .data_phase     (state_q == ST_DATA),
    .prescale       (prescale_r),
    .bit_tick       (bit_tick),
    .last_bit       (last_bit),
    .bit_nxt        (bit_nxt),
    .final_edge_nxt (final_edge_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:   if (DATA_VALID) state_nxt = ST_START;
      ST_START:  if (bit_tick) state_nxt = ST_DATA;
      ST_DATA:   if (bit_tick && last_bit) state_nxt = par_en_r ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_tick) state_nxt = ST_STOP;
      ST_STOP:   if (bit_tick) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // The line level is derived from where the FSM will be after this edge,
  // so TX_OUT can be a plain register yet change in the same cycle as state.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = data_r[bit_nxt];
      ST_PARITY: tx_nxt = parity_bit(data_r, par_typ_r);
      default:   tx_nxt = 1'b1;
    endcase
  end

  // Frame configuration is frozen at acceptance; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_en_r   <= 1'b0;
      par_typ_r  <= PAR_EVEN;
      prescale_r <= '0;
    end else if (accept) begin
      par_en_r   <= PAR_EN;
      par_typ_r  <= PAR_TYP;
      prescale_r <= prescale;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data_r <= P_DATA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tx_q   <= tx_nxt;
      busy_q <= (state_nxt != ST_IDLE);
      done_q <= (state_nxt == ST_STOP) && final_edge_nxt;
    end
  end

  assign TX_OUT     = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] prescale;
  logic       TX_OUT;
  logic       busy;
  logic       frame_done;

  int n_checks;
  int n_pass;

  typedef struct {
    logic tx;
    logic bsy;
    logic fd;
  } cyc_t;

  cyc_t exp_q[$];

  uart_tx_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescale   (prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int idx, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, idx, obs, expv);
  endtask

  // Reference model: line value per cycle from the frame bit list, each bit
  // repeated P times, followed by one idle-high cycle.
  function automatic void model_frame(input logic [7:0] b, input logic pe,
                                      input logic pt, input logic [5:0] ps);
    logic bits[$];
    int   p;
    int   total;
    cyc_t c;
    p = (ps == 6'd0) ? 64 : int'(ps);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (pe) begin
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      bits.push_back(((ones % 2) == 1) ^ pt);
    end
    bits.push_back(1'b1);
    total = bits.size() * p;
    for (int k = 0; k < total; k++) begin
      c.tx  = bits[k / p];
      c.bsy = 1'b1;
      c.fd  = (k == total - 1);
      exp_q.push_back(c);
    end
    c.tx = 1'b1; c.bsy = 1'b0; c.fd = 1'b0;
    exp_q.push_back(c);
  endfunction

  // Compare n cycles against the model. scramble=1 randomises all inputs
  // while the frame is in progress (requests must be dropped, config ignored)
  // and keeps DATA_VALID low in idle cycles.
  task automatic check_cycles(input string tag, input int n, input bit scramble);
    cyc_t e;
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) begin
        chk({tag, ".model_empty"}, k, 1'b1, 1'b0);
        return;
      end
      e = exp_q.pop_front();
      chk({tag, ".tx"},   k, TX_OUT,     e.tx);
      chk({tag, ".busy"}, k, busy,       e.bsy);
      chk({tag, ".done"}, k, frame_done, e.fd);
      if (scramble) begin
        P_DATA     = 8'($urandom);
        PAR_EN     = 1'($urandom);
        PAR_TYP    = 1'($urandom);
        prescale   = 6'($urandom);
        DATA_VALID = e.bsy ? 1'($urandom) : 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input string tag, input logic [7:0] b, input logic pe,
                      input logic pt, input logic [5:0] ps, input bit scramble);
    int p;
    p = (ps == 6'd0) ? 64 : int'(ps);
    P_DATA = b; PAR_EN = pe; PAR_TYP = pt; prescale = ps; DATA_VALID = 1'b1;
    @(posedge clk); #1;
    DATA_VALID = 1'b0;
    exp_q.delete();
    model_frame(b, pe, pt, ps);
    check_cycles(tag, (10 + int'(pe)) * p + 1, scramble);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; DATA_VALID = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0;
    PAR_TYP = 1'b0; prescale = 6'd8;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.tx",   0, TX_OUT,     1'b1);
    chk("reset.busy", 0, busy,       1'b0);
    chk("reset.done", 0, frame_done, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic frame, no parity
    send("a5_p8", 8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);

    // Parity even / odd
    send("03_even", 8'h03, 1'b1, 1'b0, 6'd4, 1'b0);
    send("03_odd",  8'h03, 1'b1, 1'b1, 6'd4, 1'b0);

    // Requests and input changes during a frame must be ignored
    send("f0_drop", 8'hF0, 1'b0, 1'b0, 6'd8, 1'b1);

    // DATA_VALID held high: back-to-back frames, one idle cycle between
    P_DATA = 8'h01; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd16; DATA_VALID = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    model_frame(8'h01, 1'b0, 1'b0, 6'd16);
    model_frame(8'h80, 1'b0, 1'b0, 6'd16);
    check_cycles("b2b_1", 160, 1'b0);
    P_DATA = 8'h80;
    check_cycles("b2b_2", 161, 1'b0);
    DATA_VALID = 1'b0;
    check_cycles("b2b_idle", 1, 1'b0);

    // Asynchronous reset in data bit 3
    P_DATA = 8'hC3; PAR_EN = 1'b0; prescale = 6'd4; DATA_VALID = 1'b1;
    @(posedge clk); #1;
    DATA_VALID = 1'b0;
    exp_q.delete();
    model_frame(8'hC3, 1'b0, 1'b0, 6'd4);
    check_cycles("pre_rst", 18, 1'b0);
    exp_q.delete();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.tx",   0, TX_OUT,     1'b1);
    chk("async_rst.busy", 0, busy,       1'b0);
    chk("async_rst.done", 0, frame_done, 1'b0);
    DATA_VALID = 1'b1;
    @(posedge clk); #1;
    chk("rst_wins.tx",   0, TX_OUT, 1'b1);
    chk("rst_wins.busy", 0, busy,   1'b0);
    DATA_VALID = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst.tx",   0, TX_OUT, 1'b1);
    chk("post_rst.busy", 0, busy,   1'b0);
    send("clean_after_rst", 8'h3C, 1'b0, 1'b0, 6'd4, 1'b0);

    // Prescale extremes; second frame also scrambles prescale mid-frame
    send("ff_p1",  8'hFF, 1'b0, 1'b0, 6'd1, 1'b0);
    send("ff_p64", 8'hFF, 1'b1, 1'b1, 6'd0, 1'b1);

    // Random frames
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      logic       pe;
      logic       pt;
      logic [5:0] ps;
      b  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      ps = (i == 5) ? 6'd0 : 6'($urandom_range(1, 12));
      send("rand", b, pe, pt, ps, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
